// File: rtl/demux_1a3_reg_if.sv
// Handshake bundle for the registered 1-to-3 demultiplexer: one producer stream in,
// three buffered consumer channels out, plus the discard counter.
interface demux_1a3_reg_if #(
    parameter int unsigned ANCHO     = 32,
    parameter int unsigned ANCHO_CNT = 8
);
    logic [ANCHO-1:0]     entrada;
    logic [1:0]           sel;
    logic                 entrada_valida;
    logic                 entrada_lista;
    logic [ANCHO-1:0]     salida_a;
    logic                 valida_a;
    logic                 lista_a;
    logic [ANCHO-1:0]     salida_b;
    logic                 valida_b;
    logic                 lista_b;
    logic [ANCHO-1:0]     salida_c;
    logic                 valida_c;
    logic                 lista_c;
    logic [ANCHO_CNT-1:0] descartes;

    // Producer and consumers together drive the block from this side.
    modport master (
        output entrada, sel, entrada_valida, lista_a, lista_b, lista_c,
        input  entrada_lista, salida_a, valida_a, salida_b, valida_b, salida_c, valida_c,
               descartes
    );

    modport slave (
        input  entrada, sel, entrada_valida, lista_a, lista_b, lista_c,
        output entrada_lista, salida_a, valida_a, salida_b, valida_b, salida_c, valida_c,
               descartes
    );
endinterface

// File: rtl/demux_1a3_reg.sv
// Registered 1-to-3 demultiplexer: steers each accepted word into one of three
// single-entry buffers by sel; sel=3 discards the word and bumps a saturating counter.
module demux_1a3_reg #(
    parameter int unsigned ANCHO     = 32,
    parameter int unsigned ANCHO_CNT = 8
) (
    input logic           clk,
    input logic           rst,
    demux_1a3_reg_if.slave bus
);
    logic [2:0]           valida_q, valida_d;
    logic [2:0]           lista;
    logic [2:0]           carga;
    logic [2:0]           drena;
    logic [ANCHO-1:0]     salida_q [3];
    logic [ANCHO-1:0]     salida_d [3];
    logic [ANCHO_CNT-1:0] descartes_q, descartes_d;
    logic                 listo;
    logic                 acepta;

    assign lista = {bus.lista_c, bus.lista_b, bus.lista_a};

    // A full buffer can still accept when its consumer drains in the same cycle.
    always_comb begin
        listo = 1'b1;
        case (bus.sel)
            2'd0:    listo = !valida_q[0] || lista[0];
            2'd1:    listo = !valida_q[1] || lista[1];
            2'd2:    listo = !valida_q[2] || lista[2];
            default: listo = 1'b1;
        endcase
    end

    assign acepta = bus.entrada_valida && listo;

    always_comb begin
        carga    = '0;
        drena    = '0;
        valida_d = valida_q;
        for (int i = 0; i < 3; i++) begin
            salida_d[i] = salida_q[i];
        end
        for (int i = 0; i < 3; i++) begin
            carga[i]    = acepta && (bus.sel == 2'(i));
            drena[i]    = valida_q[i] && lista[i];
            valida_d[i] = carga[i] || (valida_q[i] && !drena[i]);
            if (carga[i]) begin
                salida_d[i] = bus.entrada;
            end
        end
    end

    always_comb begin
        descartes_d = descartes_q;
        if (acepta && (bus.sel == 2'd3) && (descartes_q != {ANCHO_CNT{1'b1}})) begin
            descartes_d = descartes_q + ANCHO_CNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valida_q    <= '0;
            descartes_q <= '0;
            for (int i = 0; i < 3; i++) begin
                salida_q[i] <= '0;
            end
        end else begin
            valida_q    <= valida_d;
            descartes_q <= descartes_d;
            for (int i = 0; i < 3; i++) begin
                salida_q[i] <= salida_d[i];
            end
        end
    end

    assign bus.entrada_lista = listo;
    assign bus.salida_a      = salida_q[0];
    assign bus.salida_b      = salida_q[1];
    assign bus.salida_c      = salida_q[2];
    assign bus.valida_a      = valida_q[0];
    assign bus.valida_b      = valida_q[1];
    assign bus.valida_c      = valida_q[2];
    assign bus.descartes     = descartes_q;
endmodule

// File: tb/tb_demux_1a3_reg.sv
// Self-checking bench for demux_1a3_reg: directed scenarios plus a randomized run,
// all compared against a behavioural buffer/counter model.
module tb_demux_1a3_reg;
    localparam int unsigned ANCHO     = 32;
    localparam int unsigned ANCHO_CNT = 8;
    localparam int          CNT_MAX   = (1 << ANCHO_CNT) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    demux_1a3_reg_if #(.ANCHO(ANCHO), .ANCHO_CNT(ANCHO_CNT)) bus ();

    demux_1a3_reg #(.ANCHO(ANCHO), .ANCHO_CNT(ANCHO_CNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: one valid flag and one data word per channel, plus the drop count.
    bit        m_v [3];
    bit [31:0] m_d [3];
    int        m_cnt;

    logic [2:0]  dut_v;
    logic [31:0] dut_d [3];
    always_comb begin
        dut_v    = {bus.valida_c, bus.valida_b, bus.valida_a};
        dut_d[0] = bus.salida_a;
        dut_d[1] = bus.salida_b;
        dut_d[2] = bus.salida_c;
    end

    function automatic bit model_ready();
        bit [2:0] l;
        l = {bus.lista_c, bus.lista_b, bus.lista_a};
        if (bus.sel == 2'd3) return 1'b1;
        return !m_v[bus.sel] || l[bus.sel];
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit        acc;
        bit [2:0]  l;
        bit        nv [3];
        bit [31:0] nd [3];
        int        nc;
        l   = {bus.lista_c, bus.lista_b, bus.lista_a};
        acc = bus.entrada_valida && model_ready();
        nc  = m_cnt;
        for (int i = 0; i < 3; i++) begin
            nv[i] = m_v[i];
            nd[i] = m_d[i];
            if (acc && bus.sel == 2'(i)) begin
                nv[i] = 1'b1;
                nd[i] = bus.entrada;
            end else if (m_v[i] && l[i]) begin
                nv[i] = 1'b0;
            end
        end
        if (acc && bus.sel == 2'd3 && nc < CNT_MAX) nc++;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                nv[i] = 1'b0;
                nd[i] = '0;
            end
            nc = 0;
        end
        @(posedge clk);
        #1;
        m_v   = nv;
        m_d   = nd;
        m_cnt = nc;
    endtask

    task automatic drive(input bit v, input bit [1:0] s, input bit [31:0] d);
        bus.entrada_valida = v;
        bus.sel            = s;
        bus.entrada        = d;
    endtask

    task automatic set_lista(input bit [2:0] l);
        {bus.lista_c, bus.lista_b, bus.lista_a} = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_lista(3'b111);
        drive(1'b1, 2'd0, 32'hFFFF_FFFF);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (dut_v !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 000", dut_v);
        end
        checks++;
        if (bus.descartes !== '0) begin
            errors++;
            $display("FAIL reset_descartes: got %0d expected 0", bus.descartes);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_d[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got %h expected 0", i, dut_d[i]);
            end
        end
    endtask

    task automatic test_single();
        drive(1'b1, 2'd1, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (bus.entrada_lista !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", bus.entrada_lista);
        end
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (dut_v !== 3'b010 || bus.salida_b !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_word: got v=%b b=%h expected v=010 b=deadbeef",
                     dut_v, bus.salida_b);
        end
        tick();
        checks++;
        if (dut_v !== 3'b000) begin
            errors++;
            $display("FAIL single_drain: got v=%b expected 000", dut_v);
        end
    endtask

    task automatic test_backpressure();
        set_lista(3'b000);
        drive(1'b1, 2'd0, 32'h1111_1111);
        tick();
        drive(1'b1, 2'd0, 32'h2222_2222);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.entrada_lista !== 1'b0 || bus.valida_a !== 1'b1 ||
                bus.salida_a !== 32'h1111_1111) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got rdy=%b va=%b a=%h expected 0 1 11111111",
                         i, bus.entrada_lista, bus.valida_a, bus.salida_a);
            end
            tick();
        end
        set_lista(3'b001);
        #1;
        checks++;
        if (bus.entrada_lista !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", bus.entrada_lista);
        end
        tick();
        drive(1'b0, 2'd0, 32'h0);
        set_lista(3'b000);
        checks++;
        if (bus.valida_a !== 1'b1 || bus.salida_a !== 32'h2222_2222) begin
            errors++;
            $display("FAIL bp_new_word: got va=%b a=%h expected 1 22222222",
                     bus.valida_a, bus.salida_a);
        end
    endtask

    task automatic test_streaming();
        set_lista(3'b100);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd2, 32'(i));
            #1;
            checks++;
            if (bus.entrada_lista !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.entrada_lista);
            end
            tick();
            checks++;
            if (bus.valida_c !== 1'b1 || bus.salida_c !== 32'(i)) begin
                errors++;
                $display("FAIL stream_word[%0d]: got vc=%b c=%h expected 1 %h",
                         i, bus.valida_c, bus.salida_c, 32'(i));
            end
        end
        drive(1'b0, 2'd0, 32'h0);
        tick();
        checks++;
        if (bus.valida_c !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got vc=%b expected 0", bus.valida_c);
        end
    endtask

    task automatic test_interleave();
        set_lista(3'b000);
        drive(1'b1, 2'd1, 32'hAAAA_0001);
        #1;
        checks++;
        if (bus.entrada_lista !== 1'b1) begin
            errors++;
            $display("FAIL inter_ready_b: got %b expected 1", bus.entrada_lista);
        end
        tick();
        drive(1'b1, 2'd2, 32'hBBBB_0002);
        #1;
        checks++;
        if (bus.entrada_lista !== 1'b1) begin
            errors++;
            $display("FAIL inter_ready_c: got %b expected 1", bus.entrada_lista);
        end
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (dut_v !== 3'b111 || bus.salida_a !== 32'h2222_2222 ||
            bus.salida_b !== 32'hAAAA_0001 || bus.salida_c !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL inter_contents: got v=%b a=%h b=%h c=%h expected 111 22222222 aaaa0001 bbbb0002",
                     dut_v, bus.salida_a, bus.salida_b, bus.salida_c);
        end
    endtask

    task automatic test_discard();
        set_lista(3'b111);
        tick();
        checks++;
        if (dut_v !== 3'b000) begin
            errors++;
            $display("FAIL discard_drain: got v=%b expected 000", dut_v);
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3, $urandom);
            #1;
            checks++;
            if (bus.entrada_lista !== 1'b1) begin
                errors++;
                $display("FAIL discard_ready[%0d]: got %b expected 1", i, bus.entrada_lista);
            end
            tick();
            checks++;
            if (dut_v !== 3'b000 || int'(bus.descartes) != m_cnt) begin
                errors++;
                $display("FAIL discard_count[%0d]: got v=%b cnt=%0d expected 000 %0d",
                         i, dut_v, bus.descartes, m_cnt);
            end
        end
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.descartes !== 8'd255) begin
            errors++;
            $display("FAIL discard_saturate: got %0d expected 255", bus.descartes);
        end
    endtask

    task automatic test_reset_mid();
        set_lista(3'b000);
        drive(1'b1, 2'd0, 32'h1234_5678);
        tick();
        drive(1'b1, 2'd1, 32'h8765_4321);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.valida_a !== 1'b1 || bus.valida_b !== 1'b1) begin
            errors++;
            $display("FAIL rmid_fill: got va=%b vb=%b expected 1 1", bus.valida_a, bus.valida_b);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.valida_a !== 1'b0 || bus.valida_b !== 1'b0 || bus.salida_a !== 32'h0 ||
            bus.salida_b !== 32'h0 || bus.descartes !== '0) begin
            errors++;
            $display("FAIL rmid_clear: got va=%b vb=%b a=%h b=%h cnt=%0d expected all 0",
                     bus.valida_a, bus.valida_b, bus.salida_a, bus.salida_b, bus.descartes);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom);
            set_lista(3'($urandom_range(0, 7)));
            #1;
            checks++;
            if (bus.entrada_lista !== model_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b",
                         n, bus.entrada_lista, model_ready());
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_v[i] !== m_v[i] || dut_d[i] !== m_d[i]) begin
                    errors++;
                    $display("FAIL rand_ch%0d[%0d]: got v=%b d=%h expected v=%b d=%h",
                             i, n, dut_v[i], dut_d[i], m_v[i], m_d[i]);
                end
            end
            checks++;
            if (int'(bus.descartes) != m_cnt) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, bus.descartes, m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 2'd0, 32'h0);
        set_lista(3'b000);
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_interleave();
        test_discard();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
